// File: rtl/pd_ctrl_pkg.sv
// Shared types and RV32I opcode constants for the decode-stage hazard controller.
// The opcode constants live here once and every other file imports them.
package pd_ctrl_pkg;

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    // Operand source select for the EX operand muxes
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    // Hazard controller states
    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1,
        HZ_FLUSH = 2'd2
    } hz_state_e;

    // One in-flight destination register
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    // Opcode classes that write a destination register
    function automatic logic op_writes_rd(input logic [6:0] op);
        logic r;
        case (op)
            OPCODE_RTYPE, OPCODE_ITYPE, OPCODE_LOAD, OPCODE_JALR,
            OPCODE_JAL, OPCODE_LUI, OPCODE_AUIPC: r = 1'b1;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

    // Opcode classes that read rs1
    function automatic logic op_uses_rs1(input logic [6:0] op);
        logic r;
        case (op)
            OPCODE_RTYPE, OPCODE_ITYPE, OPCODE_LOAD, OPCODE_JALR,
            OPCODE_STORE, OPCODE_BRANCH: r = 1'b1;
            default:                     r = 1'b0;
        endcase
        return r;
    endfunction

    // Opcode classes that read rs2
    function automatic logic op_uses_rs2(input logic [6:0] op);
        logic r;
        case (op)
            OPCODE_RTYPE, OPCODE_STORE, OPCODE_BRANCH: r = 1'b1;
            default:                                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry EX/MEM/WB shadow of in-flight destination registers.
// Produces the load-use hazard flag and per-operand forward selects
// combinationally from the registered entries and the decoded sources.
module hazard_scoreboard
    import pd_ctrl_pkg::*;
#(
    parameter int LOAD_USE_STALLS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ins_valid_i,
    input  logic [4:0] ins_rd_i,
    input  logic       ins_is_load_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       use_rs1_i,
    input  logic       use_rs2_i,
    output logic       load_use_o,
    output logic [1:0] fwd_rs1_o,
    output logic [1:0] fwd_rs2_o
);

    sb_entry_t ex_q, ex_d;
    sb_entry_t mem_q, mem_d;
    sb_entry_t wb_q, wb_d;

    // WB entries only forward; a load in WB no longer causes a hazard
    logic wb_is_load_unused;
    assign wb_is_load_unused = wb_q.is_load;

    // An entry matches an operand only if both are live and the register is not x0
    function automatic logic entry_match(input sb_entry_t e, input logic [4:0] rs,
                                         input logic used);
        return e.valid && used && (rs != 5'd0) && (e.rd == rs);
    endfunction

    // Youngest producer wins; a load in EX cannot forward (data not ready yet)
    function automatic fwd_sel_e pick_src(input sb_entry_t ex, input sb_entry_t mem,
                                          input sb_entry_t wb, input logic [4:0] rs,
                                          input logic used);
        fwd_sel_e sel;
        if (entry_match(ex, rs, used) && !ex.is_load) begin
            sel = FWD_EX;
        end else if (entry_match(mem, rs, used)) begin
            sel = FWD_MEM;
        end else if (entry_match(wb, rs, used)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Shift the pipeline shadow; EX takes the newly issued instruction or a hole
    always_comb begin
        ex_d = '0;
        if (ins_valid_i) begin
            ex_d.valid   = 1'b1;
            ex_d.rd      = ins_rd_i;
            ex_d.is_load = ins_is_load_i;
        end
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    // Scoreboard registers, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // Load-use detection; the two-cycle variant also guards a load still in MEM
    always_comb begin
        load_use_o = 1'b0;
        if (ex_q.is_load &&
            (entry_match(ex_q, rs1_i, use_rs1_i) || entry_match(ex_q, rs2_i, use_rs2_i))) begin
            load_use_o = 1'b1;
        end
        if ((LOAD_USE_STALLS >= 2) && mem_q.is_load &&
            (entry_match(mem_q, rs1_i, use_rs1_i) || entry_match(mem_q, rs2_i, use_rs2_i))) begin
            load_use_o = 1'b1;
        end
    end

    // Forward selects are independent of whether decode holds a valid instruction
    always_comb begin
        fwd_rs1_o = pick_src(ex_q, mem_q, wb_q, rs1_i, use_rs1_i);
        fwd_rs2_o = pick_src(ex_q, mem_q, wb_q, rs2_i, use_rs2_i);
    end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage pipeline controller for the 5-stage RV32I core.
// Decodes operand usage, drives stall/bubble/flush through a small FSM and
// keeps saturating stall/flush performance counters. Forwarding and hazard
// matching come from the hazard_scoreboard sub-module.
module decode_hazard_ctrl
    import pd_ctrl_pkg::*;
#(
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid_i,
    input  logic [6:0]           id_opcode_i,
    input  logic [4:0]           id_rd_i,
    input  logic [4:0]           id_rs1_i,
    input  logic [4:0]           id_rs2_i,
    input  logic                 ex_redirect_i,
    output logic                 stall_o,
    output logic                 bubble_o,
    output logic                 flush_o,
    output logic [1:0]           fwd_rs1_o,
    output logic [1:0]           fwd_rs2_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    hz_state_e            state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic use_rs1, use_rs2, writes_rd, is_load;
    logic ins_valid, load_use, hazard;

    // Operand usage and destination classification of the decoded instruction
    always_comb begin
        use_rs1   = op_uses_rs1(id_opcode_i);
        use_rs2   = op_uses_rs2(id_opcode_i);
        writes_rd = op_writes_rd(id_opcode_i) && (id_rd_i != 5'd0);
        is_load   = (id_opcode_i == OPCODE_LOAD);
    end

    // Only an instruction that actually leaves decode enters the EX shadow
    assign ins_valid = id_valid_i && writes_rd && !stall_o && !flush_o;
    assign hazard    = id_valid_i && load_use;

    hazard_scoreboard #(
        .LOAD_USE_STALLS(LOAD_USE_STALLS)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .ins_valid_i  (ins_valid),
        .ins_rd_i     (id_rd_i),
        .ins_is_load_i(is_load),
        .rs1_i        (id_rs1_i),
        .rs2_i        (id_rs2_i),
        .use_rs1_i    (use_rs1),
        .use_rs2_i    (use_rs2),
        .load_use_o   (load_use),
        .fwd_rs1_o    (fwd_rs1_o),
        .fwd_rs2_o    (fwd_rs2_o)
    );

    // Next-state and control outputs; redirect always outranks a stall
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_o  = 1'b0;
        bubble_o = 1'b0;
        flush_o  = 1'b0;
        case (state_q)
            HZ_RUN: begin
                if (ex_redirect_i) begin
                    flush_o = 1'b1;
                    state_d = HZ_FLUSH;
                end else if (hazard) begin
                    stall_o  = 1'b1;
                    bubble_o = 1'b1;
                    cnt_d    = 2'(LOAD_USE_STALLS - 1);
                    if (cnt_d != 2'd0) begin
                        state_d = HZ_STALL;
                    end
                end
            end
            HZ_STALL: begin
                if (ex_redirect_i) begin
                    flush_o = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = HZ_FLUSH;
                end else begin
                    stall_o  = 1'b1;
                    bubble_o = 1'b1;
                    cnt_d    = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        cnt_d   = 2'd0;
                        state_d = HZ_RUN;
                    end
                end
            end
            HZ_FLUSH: begin
                if (ex_redirect_i) begin
                    flush_o = 1'b1;
                end else begin
                    state_d = HZ_RUN;
                end
            end
            default: begin
                state_d = HZ_RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Saturating performance counters, counted in the cycle the condition is seen
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (flush_o && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    // FSM and counter registers, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HZ_RUN;
            cnt_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl: one instance with default parameters,
// one with two load-use stall cycles and 4-bit counters, sharing the inputs.
module tb_decode_hazard_ctrl;
    import pd_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic       ex_redirect;

    logic        stall, bubble, flush;
    logic [1:0]  fwd1, fwd2;
    logic [31:0] stall_cnt, flush_cnt;

    logic        stall2, bubble2, flush2;
    logic [1:0]  fwd1_2, fwd2_2;
    logic [3:0]  stall_cnt2, flush_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_hazard_ctrl #(.LOAD_USE_STALLS(1), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_opcode_i(id_opcode),
        .id_rd_i(id_rd), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .ex_redirect_i(ex_redirect),
        .stall_o(stall), .bubble_o(bubble), .flush_o(flush),
        .fwd_rs1_o(fwd1), .fwd_rs2_o(fwd2),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    decode_hazard_ctrl #(.LOAD_USE_STALLS(2), .CNT_WIDTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_opcode_i(id_opcode),
        .id_rd_i(id_rd), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .ex_redirect_i(ex_redirect),
        .stall_o(stall2), .bubble_o(bubble2), .flush_o(flush2),
        .fwd_rs1_o(fwd1_2), .fwd_rs2_o(fwd2_2),
        .stall_cnt_o(stall_cnt2), .flush_cnt_o(flush_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic rdr);
        id_valid    = v;
        id_opcode   = op;
        id_rd       = d;
        id_rs1      = s1;
        id_rs2      = s2;
        ex_redirect = rdr;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        idle();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        // Reset state
        idle();
        tick();
        chk("rst_stall",     32'(stall),      32'd0);
        chk("rst_bubble",    32'(bubble),     32'd0);
        chk("rst_flush",     32'(flush),      32'd0);
        chk("rst_fwd1",      32'(fwd1),       32'd0);
        chk("rst_fwd2",      32'(fwd2),       32'd0);
        chk("rst_stall_cnt", stall_cnt,       32'd0);
        chk("rst_flush_cnt", flush_cnt,       32'd0);
        chk("rst_flush_cnt2", 32'(flush_cnt2), 32'd0);
        #1 rst = 1'b1;

        // 1: lw x5,0(x1); add x6,x5,x2
        drive(1'b1, OPCODE_LOAD, 5'd5, 5'd1, 5'd0, 1'b0);
        chk("t1_lw_nostall", 32'(stall), 32'd0);
        tick();
        drive(1'b1, OPCODE_RTYPE, 5'd6, 5'd5, 5'd2, 1'b0);
        chk("t1_stall",  32'(stall),  32'd1);
        chk("t1_bubble", 32'(bubble), 32'd1);
        tick();
        chk("t1_stall_after", 32'(stall), 32'd0);
        chk("t1_fwd1_mem",    32'(fwd1),  32'd2);
        chk("t1_fwd2_rf",     32'(fwd2),  32'd0);
        chk("t1_stall_cnt",   stall_cnt,  32'd1);

        // 2: EX forwarding and youngest-first priority
        reset_pulse();
        drive(1'b1, OPCODE_ITYPE, 5'd3, 5'd0, 5'd1, 1'b0);    // addi x3,x0,1
        tick();
        drive(1'b1, OPCODE_ITYPE, 5'd3, 5'd3, 5'd3, 1'b0);    // addi x3,x3,..
        chk("t2_addi_fwd1_ex",   32'(fwd1), 32'd1);
        chk("t2_addi_rs2_unused", 32'(fwd2), 32'd0);
        tick();
        drive(1'b1, OPCODE_RTYPE, 5'd4, 5'd3, 5'd3, 1'b0);    // sub x4,x3,x3
        chk("t2_sub_stall", 32'(stall), 32'd0);
        chk("t2_sub_fwd1",  32'(fwd1),  32'd1);
        chk("t2_sub_fwd2",  32'(fwd2),  32'd1);
        tick();
        drive(1'b1, OPCODE_RTYPE, 5'd7, 5'd3, 5'd4, 1'b0);    // add x7,x3,x4
        chk("t2_add_fwd1_mem", 32'(fwd1), 32'd2);
        chk("t2_add_fwd2_ex",  32'(fwd2), 32'd1);
        tick();
        drive(1'b0, OPCODE_RTYPE, 5'd0, 5'd3, 5'd4, 1'b0);    // invalid slot
        chk("t2_inv_fwd1_wb",  32'(fwd1), 32'd3);
        chk("t2_inv_fwd2_mem", 32'(fwd2), 32'd2);

        // 3: x0 never matches; store uses rs2
        reset_pulse();
        drive(1'b1, OPCODE_LOAD, 5'd0, 5'd1, 5'd0, 1'b0);     // lw x0,0(x1)
        tick();
        drive(1'b1, OPCODE_RTYPE, 5'd6, 5'd0, 5'd0, 1'b0);    // add x6,x0,x0
        chk("t3_x0_stall", 32'(stall), 32'd0);
        chk("t3_x0_fwd1",  32'(fwd1),  32'd0);
        chk("t3_x0_fwd2",  32'(fwd2),  32'd0);
        tick();
        drive(1'b1, OPCODE_LOAD, 5'd5, 5'd1, 5'd0, 1'b0);     // lw x5,0(x1)
        tick();
        drive(1'b1, OPCODE_STORE, 5'd0, 5'd2, 5'd5, 1'b0);    // sw x5,0(x2)
        chk("t3_sw_stall",  32'(stall),  32'd1);
        chk("t3_sw_bubble", 32'(bubble), 32'd1);

        // 4: load-use with simultaneous redirect; redirect inside FLUSH
        reset_pulse();
        drive(1'b1, OPCODE_LOAD, 5'd5, 5'd1, 5'd0, 1'b0);
        tick();
        drive(1'b1, OPCODE_RTYPE, 5'd6, 5'd5, 5'd2, 1'b1);
        chk("t4_flush",  32'(flush),  32'd1);
        chk("t4_stall",  32'(stall),  32'd0);
        chk("t4_bubble", 32'(bubble), 32'd0);
        tick();
        chk("t4_flush_cnt", flush_cnt, 32'd1);
        chk("t4_stall_cnt", stall_cnt, 32'd0);
        drive(1'b0, OPCODE_RTYPE, 5'd0, 5'd5, 5'd0, 1'b0);
        chk("t4_flushst_flush", 32'(flush), 32'd0);
        chk("t4_flushst_stall", 32'(stall), 32'd0);
        chk("t4_flushst_fwd1",  32'(fwd1),  32'd2);
        tick();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        chk("t4_reflush_in_flush", 32'(flush), 32'd1);
        tick();
        idle();
        chk("t4_flush_drop", 32'(flush), 32'd0);
        chk("t4_flush_cnt3", flush_cnt,  32'd3);

        // 5: two stall cycles, then WB forwarding
        reset_pulse();
        drive(1'b1, OPCODE_LOAD, 5'd7, 5'd1, 5'd0, 1'b0);     // lw x7,0(x1)
        tick();
        drive(1'b1, OPCODE_BRANCH, 5'd0, 5'd7, 5'd0, 1'b0);   // beq x7,x0
        chk("t5_stall_c1", 32'(stall2), 32'd1);
        tick();
        chk("t5_stall_c2",  32'(stall2),  32'd1);
        chk("t5_bubble_c2", 32'(bubble2), 32'd1);
        tick();
        chk("t5_stall_done", 32'(stall2),    32'd0);
        chk("t5_fwd1_wb",    32'(fwd1_2),    32'd3);
        chk("t5_fwd2_x0",    32'(fwd2_2),    32'd0);
        chk("t5_stall_cnt",  32'(stall_cnt2), 32'd2);

        // Redirect aborts a STALL
        reset_pulse();
        drive(1'b1, OPCODE_LOAD, 5'd7, 5'd1, 5'd0, 1'b0);
        tick();
        drive(1'b1, OPCODE_BRANCH, 5'd0, 5'd7, 5'd0, 1'b0);
        tick();
        drive(1'b1, OPCODE_BRANCH, 5'd0, 5'd7, 5'd0, 1'b1);
        chk("t5_abort_flush", 32'(flush2), 32'd1);
        chk("t5_abort_stall", 32'(stall2), 32'd0);
        tick();
        chk("t5_abort_flush_cnt", 32'(flush_cnt2), 32'd1);
        chk("t5_abort_stall_cnt", 32'(stall_cnt2), 32'd1);

        // 6: reset dropped mid-STALL
        reset_pulse();
        drive(1'b1, OPCODE_LOAD, 5'd7, 5'd1, 5'd0, 1'b0);
        tick();
        drive(1'b1, OPCODE_BRANCH, 5'd0, 5'd7, 5'd0, 1'b0);
        tick();
        chk("t6_in_stall", 32'(stall2), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_stall",  32'(stall2),     32'd0);
        chk("t6_rst_bubble", 32'(bubble2),    32'd0);
        chk("t6_rst_fwd1",   32'(fwd1_2),     32'd0);
        chk("t6_rst_cnt",    32'(stall_cnt2), 32'd0);
        rst = 1'b1;
        #1;
        chk("t6_after_rst_stall", 32'(stall2), 32'd0);
        tick();
        chk("t6_after_rst_run", 32'(stall2), 32'd0);

        // Counter saturation on the 4-bit instance
        reset_pulse();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        repeat (20) tick();
        chk("t6_flush_cnt2_sat", 32'(flush_cnt2), 32'd15);
        chk("t6_flush_cnt_wide", flush_cnt,       32'd20);
        chk("t6_flush_held",     32'(flush2),     32'd1);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
